ttl_pulse_train: RTL and testbench

TTL_PULSE_TRAIN -- requirements
Module: ttl_pulse_train

---
 rtl/ttl_pulse_train.sv | 158 +++++++++++++++
 tb/tb_ttl_pulse_train.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_pulse_train.sv
// ttl_pulse_train: tagged-command driven TTL pulse-train generator with override and drop reporting.
// Revision 1.0
`default_nettype none

module ttl_pulse_train #(
  parameter logic [15:0] DEST_VAL = 16'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         counter_matched,
  input  logic [127:0] gpo_in,
  input  logic         override_en,
  input  logic [7:0]   override_value,
  output logic         output_pulse_0,
  output logic         output_pulse_1,
  output logic         output_pulse_2,
  output logic         output_pulse_3,
  output logic         output_pulse_4,
  output logic         output_pulse_5,
  output logic         output_pulse_6,
  output logic         output_pulse_7,
  output logic         busy,
  output logic         done,
  output logic         busy_error,
  output logic [127:0] error_data,
  output logic         overrided
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [31:0]  phase_q, phase_d;
  logic [15:0]  pulses_q, pulses_d;
  logic [31:0]  high_q, high_d;
  logic [31:0]  low_q, low_d;
  logic [7:0]   mask_q, mask_d;
  logic [7:0]   lines_q, lines_d;
  logic         done_q, done_d;
  logic         berr_q, berr_d;
  logic [127:0] err_q, err_d;
  logic         ovr_q;

  logic [15:0]  w_dest;
  logic [15:0]  w_count;
  logic [31:0]  w_low_eff;
  logic [31:0]  w_high_eff;
  logic         w_accept;

  assign w_dest     = gpo_in[127:112];
  assign w_count    = gpo_in[87:72];
  assign w_low_eff  = (gpo_in[71:40] == 32'd0) ? 32'd1 : gpo_in[71:40];
  assign w_high_eff = (gpo_in[39:8]  == 32'd0) ? 32'd1 : gpo_in[39:8];
  assign w_accept   = counter_matched && (w_dest == DEST_VAL);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pulses_d = pulses_q;
    high_d   = high_q;
    low_d    = low_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    berr_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept && (w_count != 16'd0)) begin
          state_d  = ST_HIGH;
          mask_d   = gpo_in[7:0];
          high_d   = w_high_eff;
          low_d    = w_low_eff;
          pulses_d = w_count;
          phase_d  = w_high_eff - 32'd1;
        end
      end
      ST_HIGH: begin
        if (phase_q == 32'd0) begin
          // Last high phase ends the train directly; no trailing low phase.
          if (pulses_q <= 16'd1) begin
            state_d  = ST_IDLE;
            pulses_d = 16'd0;
            done_d   = 1'b1;
          end else begin
            state_d  = ST_LOW;
            pulses_d = pulses_q - 16'd1;
            phase_d  = low_q - 32'd1;
          end
        end else begin
          phase_d = phase_q - 32'd1;
        end
      end
      ST_LOW: begin
        if (phase_q == 32'd0) begin
          state_d = ST_HIGH;
          phase_d = high_q - 32'd1;
        end else begin
          phase_d = phase_q - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_accept && (state_q != ST_IDLE)) begin
      berr_d = 1'b1;
      err_d  = gpo_in;
    end

    lines_d = override_en ? override_value : ((state_d == ST_HIGH) ? mask_d : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= 32'd0;
      pulses_q <= 16'd0;
      high_q   <= 32'd0;
      low_q    <= 32'd0;
      mask_q   <= 8'h00;
      lines_q  <= 8'h00;
      done_q   <= 1'b0;
      berr_q   <= 1'b0;
      err_q    <= 128'd0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pulses_q <= pulses_d;
      high_q   <= high_d;
      low_q    <= low_d;
      mask_q   <= mask_d;
      lines_q  <= lines_d;
      done_q   <= done_d;
      berr_q   <= berr_d;
      err_q    <= err_d;
      ovr_q    <= override_en;
    end
  end

  assign output_pulse_0 = lines_q[0];
  assign output_pulse_1 = lines_q[1];
  assign output_pulse_2 = lines_q[2];
  assign output_pulse_3 = lines_q[3];
  assign output_pulse_4 = lines_q[4];
  assign output_pulse_5 = lines_q[5];
  assign output_pulse_6 = lines_q[6];
  assign output_pulse_7 = lines_q[7];
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign busy_error     = berr_q;
  assign error_data     = err_q;
  assign overrided      = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_ttl_pulse_train.sv
// tb_ttl_pulse_train: directed and random stimulus against a schedule-based reference model.
// Revision 1.0
`default_nettype none

module tb_ttl_pulse_train;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cm = 1'b0;
  logic [127:0] gpo = 128'd0;
  logic         ov_en = 1'b0;
  logic [7:0]   ov_val = 8'h00;
  logic [7:0]   lines;
  logic         busy, done, busy_error, overrided;
  logic [127:0] error_data;

  int tests = 0;
  int fails = 0;

  ttl_pulse_train dut (
    .clk(clk), .reset(reset), .counter_matched(cm), .gpo_in(gpo),
    .override_en(ov_en), .override_value(ov_val),
    .output_pulse_0(lines[0]), .output_pulse_1(lines[1]), .output_pulse_2(lines[2]),
    .output_pulse_3(lines[3]), .output_pulse_4(lines[4]), .output_pulse_5(lines[5]),
    .output_pulse_6(lines[6]), .output_pulse_7(lines[7]),
    .busy(busy), .done(done), .busy_error(busy_error),
    .error_data(error_data), .overrided(overrided)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mk(input logic [15:0] dest, input logic [15:0] n,
                                      input logic [31:0] lo, input logic [31:0] hi,
                                      input logic [7:0] mask);
    return {dest, 24'h0, n, lo, hi, mask};
  endfunction

  // Reference model: a train is a schedule starting at m_start of length
  // n*h + (n-1)*l, high whenever (k mod (h+l)) < h.
  longint       cyc = 0;
  bit           started = 0;
  bit           m_active = 0;
  longint       m_start, m_h, m_l, m_len, k;
  logic [7:0]   m_mask;
  bit           busy_c, acc, hi_ph;
  logic [7:0]   e_lines = 0;
  logic         e_busy = 0, e_done = 0, e_berr = 0, e_ovr = 0;
  logic [127:0] e_err = 0;

  always @(posedge clk) begin
    busy_c = m_active && ((cyc - m_start) < m_len);
    if (reset) begin
      m_active = 0;
      e_err = 0; e_done = 0; e_berr = 0; e_ovr = 0; e_lines = 0; e_busy = 0;
      started = 1;
    end else begin
      acc    = cm && (gpo[127:112] == 16'h0);
      e_berr = acc && busy_c;
      if (e_berr) e_err = gpo;
      e_done = m_active && ((cyc + 1 - m_start) == m_len);
      if (e_done) m_active = 0;
      if (acc && !busy_c && gpo[87:72] != 16'd0) begin
        m_active = 1;
        m_start  = cyc + 1;
        m_h      = (gpo[39:8]  == 32'd0) ? 1 : longint'(gpo[39:8]);
        m_l      = (gpo[71:40] == 32'd0) ? 1 : longint'(gpo[71:40]);
        m_mask   = gpo[7:0];
        m_len    = longint'(gpo[87:72]) * m_h + (longint'(gpo[87:72]) - 1) * m_l;
      end
      k       = cyc + 1 - m_start;
      e_busy  = m_active && (k < m_len);
      hi_ph   = e_busy && ((k % (m_h + m_l)) < m_h);
      e_lines = ov_en ? ov_val : (hi_ph ? m_mask : 8'h00);
      e_ovr   = ov_en;
    end
    cyc++;
    #1;
    if (started) begin
      chk("lines", {120'd0, lines}, {120'd0, e_lines});
      chk("busy", {127'd0, busy}, {127'd0, e_busy});
      chk("done", {127'd0, done}, {127'd0, e_done});
      chk("busy_error", {127'd0, busy_error}, {127'd0, e_berr});
      chk("overrided", {127'd0, overrided}, {127'd0, e_ovr});
      chk("error_data", error_data, e_err);
    end
  end

  // Strobes cmd in cycle 0 (optionally cmd2 in cycle at2), then records
  // line 0 and the status outputs over the following 16 cycles.
  task automatic capture(input logic [127:0] cmd, input logic [127:0] cmd2, input int at2,
                         output logic [15:0] pat0, output int busy_n, output int done_at,
                         output int berr_n);
    @(negedge clk);
    cm = 1'b1; gpo = cmd;
    pat0 = 16'h0; busy_n = 0; done_at = -1; berr_n = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      cm = 1'b0;
      pat0[i-1] = lines[0];
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = i;
      if (busy_error) berr_n++;
      if (i == at2) begin cm = 1'b1; gpo = cmd2; end
    end
    cm = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  logic [15:0]  pat;
  int           bn, da, en;
  logic [127:0] cmd_b;
  int           dn;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_lines", {120'd0, lines}, 128'd0);
    chk("reset_err_data", error_data, 128'd0);

    // 3-high / 2-low, two pulses on lines 0 and 2
    capture(mk(16'h0, 16'd2, 32'd2, 32'd3, 8'h05), 128'd0, 0, pat, bn, da, en);
    chk("basic_pattern", {112'd0, pat}, 128'h00E7);
    chk("basic_busy_cycles", 128'(bn), 128'd8);
    chk("basic_done_cycle", 128'(da), 128'd9);

    // foreign destination tag is ignored
    capture(mk(16'h1, 16'd2, 32'd2, 32'd3, 8'hFF), 128'd0, 0, pat, bn, da, en);
    chk("foreign_pattern", {112'd0, pat}, 128'd0);
    chk("foreign_busy", 128'(bn), 128'd0);
    chk("foreign_berr", 128'(en), 128'd0);

    // second valid command mid-train is dropped and reported
    cmd_b = mk(16'h0, 16'd5, 32'd7, 32'd9, 8'hA5) | (128'hDEAD << 88);
    capture(mk(16'h0, 16'd3, 32'd2, 32'd2, 8'h03), cmd_b, 4, pat, bn, da, en);
    chk("drop_pattern", {112'd0, pat}, 128'h0333);
    chk("drop_busy_cycles", 128'(bn), 128'd10);
    chk("drop_done_cycle", 128'(da), 128'd11);
    chk("drop_berr_count", 128'(en), 128'd1);
    chk("drop_err_data", error_data, cmd_b);

    // zero high/low lengths behave as one cycle
    capture(mk(16'h0, 16'd3, 32'd0, 32'd0, 8'h01), 128'd0, 0, pat, bn, da, en);
    chk("zero_len_pattern", {112'd0, pat}, 128'h0015);
    chk("zero_len_busy", 128'(bn), 128'd5);
    chk("zero_len_done", 128'(da), 128'd6);

    // zero pulse count does nothing
    capture(mk(16'h0, 16'd0, 32'd1, 32'd1, 8'hFF), 128'd0, 0, pat, bn, da, en);
    chk("count0_busy", 128'(bn), 128'd0);
    chk("count0_done", 128'(da), -128'sd1);
    chk("count0_berr", 128'(en), 128'd0);

    // command in the final busy cycle (done edge) is still dropped
    cmd_b = mk(16'h0, 16'd1, 32'd1, 32'd1, 8'h3C);
    capture(mk(16'h0, 16'd2, 32'd1, 32'd1, 8'h01), cmd_b, 3, pat, bn, da, en);
    chk("edge_done_cycle", 128'(da), 128'd4);
    chk("edge_berr_count", 128'(en), 128'd1);
    chk("edge_busy_cycles", 128'(bn), 128'd3);
    chk("edge_err_data", error_data, cmd_b);

    // override mid-train, then release
    @(negedge clk);
    cm = 1'b1; gpo = mk(16'h0, 16'd3, 32'd4, 32'd4, 8'h11);
    @(negedge clk); cm = 1'b0;
    idle(2);
    ov_en = 1'b1; ov_val = 8'hFF;
    @(negedge clk);
    chk("override_lines", {120'd0, lines}, 128'hFF);
    chk("override_flag", {127'd0, overrided}, 128'd1);
    idle(4);
    ov_en = 1'b0;
    idle(20);

    // reset during the low phase aborts the train silently
    @(negedge clk);
    cm = 1'b1; gpo = mk(16'h0, 16'd2, 32'd5, 32'd3, 8'hF0);
    @(negedge clk); cm = 1'b0;
    idle(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_lines", {120'd0, lines}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 128'(dn), 128'd0);
    capture(mk(16'h0, 16'd2, 32'd2, 32'd3, 8'h05), 128'd0, 0, pat, bn, da, en);
    chk("after_abort_pattern", {112'd0, pat}, 128'h00E7);
    chk("after_abort_done", 128'(da), 128'd9);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      cm    = ($urandom_range(0, 5) == 0);
      gpo   = mk(($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'h0,
                 16'($urandom_range(0, 4)), 32'($urandom_range(0, 4)),
                 32'($urandom_range(0, 4)), 8'($urandom))
              | (128'($urandom) << 88);
      if ($urandom_range(0, 39) == 0) ov_en = ~ov_en;
      ov_val = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; cm = 1'b0; ov_en = 1'b0;
    idle(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
